// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner.
//   state_t  : scanner FSM states
//   NUM_ROWS / NUM_COLS : matrix dimensions
//   KEY_MAP  : [row][col] -> 4-bit hex key code
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [3:0] KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: 2-flop synchronizer for asynchronous inputs.
// Both stages reset to all-ones (idle level of pulled-up active-low lines).
//   clk, rst_n : clock, asynchronous active-low reset
//   d          : asynchronous input bus (DATA_W bits)
//   q          : synchronized output bus
module keypad_sync #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] sync_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '1;
      q       <= '1;
    end else begin
      // stage p0: first capture, may go metastable
      sync_p0 <= d;
      // stage p1: resolved value
      q       <= sync_p0;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with press/release debounce.
// Drives one column low at a time, samples the synchronized active-low rows
// at the end of each column dwell, debounces the press, holds key_valid
// high while the key is held and debounces the release.
//   clk, rst_n : clock, asynchronous active-low reset
//   row_n[3:0] : keypad rows, active-low, asynchronous
//   col_n[3:0] : column drives, one-hot low
//   key_code   : hex code of the accepted key (kept after release)
//   key_valid  : high from press acceptance until release acceptance
// Build option: define KEYPAD_MULTIKEY_REJECT_EN to treat any sample with
// more than one row low (in SCAN or DEBOUNCE) as no press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int DWELL_W = $clog2(SCAN_DIV);
  localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);

`ifdef KEYPAD_MULTIKEY_REJECT_EN
  localparam bit MULTI_REJECT = 1'b1;
`else
  localparam bit MULTI_REJECT = 1'b0;
`endif

  function automatic logic [1:0] lowest_row(input logic [3:0] low);
    lowest_row = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (low[i]) lowest_row = 2'(i);
    end
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] c);
    col_drive = ~(4'b0001 << c);
  endfunction

  logic [3:0]         rows_s;
  logic [3:0]         rows_low;
  logic               any_low;
  logic               multi_low;
  logic               row_lat_low;

  state_t             state, state_nxt;
  logic [1:0]         col_idx, col_nxt;
  logic [1:0]         row_lat, row_nxt;
  logic [DWELL_W-1:0] dwell_cnt, dwell_nxt;
  logic [DEB_W-1:0]   deb_cnt, deb_nxt;
  logic [3:0]         code_nxt;
  logic               valid_nxt;

  keypad_sync #(.DATA_W(NUM_ROWS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row_n),
    .q     (rows_s)
  );

  assign rows_low    = ~rows_s;
  assign any_low     = |rows_low;
  // more than one bit set: clearing the lowest set bit leaves something
  assign multi_low   = (rows_low & (rows_low - 4'd1)) != 4'd0;
  assign row_lat_low = rows_low[row_lat];

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    row_nxt   = row_lat;
    dwell_nxt = dwell_cnt;
    deb_nxt   = deb_cnt;
    code_nxt  = key_code;
    valid_nxt = key_valid;

    case (state)
      SCAN: begin
        valid_nxt = 1'b0;
        if (dwell_cnt == DWELL_LAST) begin
          dwell_nxt = '0;
          if (any_low && !(MULTI_REJECT && multi_low)) begin
            state_nxt = DEBOUNCE;
            row_nxt   = lowest_row(rows_low);
            deb_nxt   = '0;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end else begin
          dwell_nxt = dwell_cnt + DWELL_W'(1);
        end
      end

      DEBOUNCE: begin
        if (!row_lat_low || (MULTI_REJECT && multi_low)) begin
          state_nxt = SCAN;
          col_nxt   = col_idx + 2'd1;
          dwell_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          // this clock is the DEBOUNCE_CYCLES-th stable one
          state_nxt = HELD;
          valid_nxt = 1'b1;
          code_nxt  = KEY_MAP[row_lat][col_idx];
        end else begin
          deb_nxt = deb_cnt + DEB_W'(1);
        end
      end

      HELD: begin
        if (!row_lat_low) begin
          state_nxt = RELEASE;
          deb_nxt   = '0;
        end
      end

      RELEASE: begin
        if (row_lat_low) begin
          deb_nxt = '0;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt = SCAN;
          valid_nxt = 1'b0;
          col_nxt   = col_idx + 2'd1;
          dwell_nxt = '0;
        end else begin
          deb_nxt = deb_cnt + DEB_W'(1);
        end
      end

      default: begin
        state_nxt = SCAN;
        valid_nxt = 1'b0;
        dwell_nxt = '0;
        deb_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      col_n     <= 4'b1110;
      row_lat   <= 2'd0;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      // column drive registered so the pins never glitch
      col_n     <= col_drive(col_nxt);
      row_lat   <= row_nxt;
      dwell_cnt <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      key_code  <= code_nxt;
      key_valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with
// SCAN_DIV=4, DEBOUNCE_CYCLES=8. A keypad model pulls a row low whenever a
// pressed key sits in the currently driven column. Expected key codes are
// queued when a press is driven and compared on each key_valid rising edge.
module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;

  logic [3:0][3:0] pressed;  // pressed[row][col]

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int kv_rises = 0;
  logic kv_prev = 1'b0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_code  (key_code),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(pressed[r] & ~col_n);
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic logic [3:0] colpat(input int c);
    colpat = ~(4'b0001 << c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_col(input int c, input int budget, output int n);
    n = 0;
    while (col_n != colpat(c) && n < budget) begin
      tick();
      n++;
    end
    check_val("col_reach", 32'(col_n), 32'(colpat(c)));
  endtask

  task automatic wait_kv(input logic lvl, input int budget, output int n);
    n = 0;
    while (key_valid != lvl && n < budget) begin
      tick();
      n++;
    end
    check_val("kv_reach", 32'(key_valid), 32'(lvl));
  endtask

  // scoreboard monitor: every key_valid rise must match a queued press
  always @(posedge clk) begin
    #1;
    if (key_valid && !kv_prev) begin
      kv_rises++;
      check_val("sb_pending", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) check_val("sb_key_code", 32'(key_code), exp_q.pop_front());
    end
    kv_prev = key_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int r0;
    int changes;
    logic [3:0] last_col;

    rst_n   = 1'b0;
    pressed = '0;
    repeat (3) tick();
    check_val("rst_col", 32'(col_n), 32'(4'b1110));
    check_val("rst_kv", 32'(key_valid), 0);
    check_val("rst_code", 32'(key_code), 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_val("scan_rot", 32'(col_n), 32'(colpat(((i + 1) / SD) % 4)));
    end

    // clean press r1,c2 -> code 6
    wait_col(1, 40, n);
    pressed[1][2] = 1'b1;
    exp_q.push_back(6);
    wait_col(2, 40, n);
    wait_kv(1'b1, 40, n);
    check_val("press_lat", n, SD + DC);
    check_val("col_frozen", 32'(col_n), 32'(colpat(2)));
    repeat (5) tick();
    check_val("held_kv", 32'(key_valid), 1);
    check_val("held_code", 32'(key_code), 6);
    pressed[1][2] = 1'b0;
    wait_kv(1'b0, 40, n);
    check_val("rel_lat", n, 2 + 1 + DC);
    check_val("rel_next_col", 32'(col_n), 32'(colpat(3)));
    check_val("rel_code_kept", 32'(key_code), 6);

    // bounce on press r2,c3 -> code C
    wait_col(2, 40, n);
    pressed[2][3] = 1'b1;
    exp_q.push_back(32'hC);
    wait_col(3, 40, n);
    repeat (6) tick();
    pressed[2][3] = 1'b0;
    tick();
    pressed[2][3] = 1'b1;
    n = 0;
    while (col_n == colpat(3) && n < 20) begin
      tick();
      n++;
    end
    check_val("abort_lat", n, 2);
    check_val("abort_col", 32'(col_n), 32'(colpat(0)));
    check_val("abort_kv", 32'(key_valid), 0);
    wait_kv(1'b1, 60, n);
    check_val("repress_lat", n, 3 * SD + SD + DC);

    // bounce on release of the held C key
    repeat (2) tick();
    pressed[2][3] = 1'b0;
    repeat (5) tick();
    check_val("relb_kv_a", 32'(key_valid), 1);
    pressed[2][3] = 1'b1;
    tick();
    pressed[2][3] = 1'b0;
    check_val("relb_kv_b", 32'(key_valid), 1);
    wait_kv(1'b0, 40, n);
    check_val("relb_lat", n, 1 + 1 + DC);
    check_val("relb_col", 32'(col_n), 32'(colpat(0)));

    // hold key 0 (r3,c1), then add key 5 (r1,c1)
    r0 = kv_rises;
    pressed[3][1] = 1'b1;
    exp_q.push_back(0);
    wait_kv(1'b1, 60, n);
    pressed[1][1] = 1'b1;
    repeat (20) tick();
    check_val("chord_code", 32'(key_code), 0);
    check_val("chord_kv", 32'(key_valid), 1);
    check_val("chord_col", 32'(col_n), 32'(colpat(1)));
    pressed[3][1] = 1'b0;
    pressed[1][1] = 1'b0;
    wait_kv(1'b0, 40, n);
    check_val("chord_rel_lat", n, 2 + 1 + DC);
    repeat (40) tick();
    check_val("chord_pulses", kv_rises - r0, 1);

    // two keys in column 0: r0 and r2
    r0 = kv_rises;
    pressed[0][0] = 1'b1;
    pressed[2][0] = 1'b1;
`ifdef KEYPAD_MULTIKEY_REJECT_EN
    changes  = 0;
    last_col = col_n;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (col_n != last_col) changes++;
      last_col = col_n;
    end
    check_val("multi_rot", changes, 40 / SD);
    check_val("multi_pulses", kv_rises - r0, 0);
    pressed[0][0] = 1'b0;
    pressed[2][0] = 1'b0;
`else
    exp_q.push_back(1);
    wait_kv(1'b1, 60, n);
    check_val("multi_code", 32'(key_code), 1);
    pressed[0][0] = 1'b0;
    pressed[2][0] = 1'b0;
    wait_kv(1'b0, 40, n);
    check_val("multi_pulses", kv_rises - r0, 1);
`endif

    // asynchronous reset while HELD on key A (r0,c3)
    pressed[0][3] = 1'b1;
    exp_q.push_back(32'hA);
    wait_kv(1'b1, 60, n);
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_kv", 32'(key_valid), 0);
    check_val("arst_col", 32'(col_n), 32'(4'b1110));
    check_val("arst_code", 32'(key_code), 0);
    pressed = '0;
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    check_val("post_rst_col", 32'(col_n), 32'(4'b1110));
    check_val("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
